// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - decodes strobed active-low 7-segment patterns into BCD digits and multi-digit frames
// Slot 0 sits in the most-significant nibble of frame; unrecognised patterns store 4'hF.

module seg7_frame_decoder #(
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  seg_valid,
   input  logic [6:0]            seg_in,
   output logic                  digit_valid,
   output logic [3:0]            digit,
   output logic [2:0]            digit_idx,
   output logic                  frame_valid,
   output logic [4*DIGITS-1:0]   frame,
   output logic                  bad_seg,
   output logic [3:0]            bad_cnt
);

   localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t                state;
   logic [2:0]            wr_idx;
   logic [4*DIGITS-1:0]   partial;

   logic [3:0]            dec_digit;
   logic                  dec_bad;
   logic [2:0]            cur_idx;
   logic                  last_slot;
   logic [4*DIGITS-1:0]   nxt_partial;

   // Exact-match table: any pattern not listed is treated as bad.
   always_comb begin
      dec_digit = 4'hF;
      case (seg_in)
         7'b1000000: dec_digit = 4'd0;
         7'b1111001: dec_digit = 4'd1;
         7'b0100100: dec_digit = 4'd2;
         7'b0110000: dec_digit = 4'd3;
         7'b0011001: dec_digit = 4'd4;
         7'b0010010: dec_digit = 4'd5;
         7'b0000010: dec_digit = 4'd6;
         7'b1011000: dec_digit = 4'd7;
         7'b0000000: dec_digit = 4'd8;
         7'b0010000: dec_digit = 4'd9;
         default:    dec_digit = 4'hF;
      endcase
      dec_bad = (dec_digit == 4'hF);
   end

   always_comb begin
      cur_idx     = (state == IDLE) ? 3'd0 : wr_idx;
      last_slot   = (cur_idx == LAST_IDX);
      nxt_partial = partial;
      nxt_partial[(DIGITS - 1 - int'(cur_idx)) * 4 +: 4] = dec_digit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_idx      <= 3'd0;
         partial     <= '0;
         frame       <= '0;
         digit_valid <= 1'b0;
         digit       <= 4'd0;
         digit_idx   <= 3'd0;
         frame_valid <= 1'b0;
         bad_seg     <= 1'b0;
         bad_cnt     <= 4'd0;
      end else begin
         digit_valid <= 1'b0;
         frame_valid <= 1'b0;
         bad_seg     <= 1'b0;
         if (clr) begin
            // Abort drops the sample and partial frame but keeps frame intact.
            state   <= IDLE;
            wr_idx  <= 3'd0;
            bad_cnt <= 4'd0;
         end else if (seg_valid) begin
            digit_valid <= 1'b1;
            digit       <= dec_digit;
            digit_idx   <= cur_idx;
            bad_seg     <= dec_bad;
            partial     <= nxt_partial;
            if (dec_bad && (bad_cnt != 4'd15)) begin
               bad_cnt <= bad_cnt + 4'd1;
            end
            if (last_slot) begin
               frame       <= nxt_partial;
               frame_valid <= 1'b1;
               state       <= IDLE;
               wr_idx      <= 3'd0;
            end else begin
               state  <= COLLECT;
               wr_idx <= cur_idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - randomized and directed self-checking bench for seg7_frame_decoder
// Reference model keeps the frame as an array of digits and looks patterns up in a table.

module tb_seg7_frame_decoder;

   localparam int DIGITS = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 clr = 1'b0;
   logic                 seg_valid = 1'b0;
   logic [6:0]           seg_in = 7'd0;
   logic                 digit_valid;
   logic [3:0]           digit;
   logic [2:0]           digit_idx;
   logic                 frame_valid;
   logic [4*DIGITS-1:0]  frame;
   logic                 bad_seg;
   logic [3:0]           bad_cnt;

   seg7_frame_decoder #(.DIGITS(DIGITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .seg_valid   (seg_valid),
      .seg_in      (seg_in),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_idx   (digit_idx),
      .frame_valid (frame_valid),
      .frame       (frame),
      .bad_seg     (bad_seg),
      .bad_cnt     (bad_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};
   logic [6:0] bad_pat = 7'b1111111;

   int         m_slot;
   int         m_bad;
   logic [3:0] m_part [DIGITS];
   logic [4*DIGITS-1:0] m_frame;
   logic [3:0] m_digit;
   int         m_idx;
   bit         m_dv, m_fv, m_bs;
   int         fv_seen, bs_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (pat[i] == p) return 4'(i);
      end
      return 4'hF;
   endfunction

   task automatic model_reset();
      m_slot = 0; m_bad = 0; m_frame = '0; m_digit = 4'd0; m_idx = 0;
      m_dv = 0; m_fv = 0; m_bs = 0;
      for (int i = 0; i < DIGITS; i++) m_part[i] = 4'd0;
   endtask

   // Called at a falling edge; applies inputs for one cycle and checks the result.
   task automatic step(input bit v, input logic [6:0] p, input bit c);
      logic [3:0] d;
      seg_valid = v; seg_in = p; clr = c;
      @(posedge clk);
      @(negedge clk);
      m_dv = 0; m_fv = 0; m_bs = 0;
      if (c) begin
         m_slot = 0;
         m_bad  = 0;
      end else if (v) begin
         d = ref_decode(p);
         m_dv = 1; m_digit = d; m_idx = m_slot;
         m_bs = (d == 4'hF);
         if (m_bs && m_bad < 15) m_bad++;
         m_part[m_slot] = d;
         if (m_slot == DIGITS - 1) begin
            m_fv = 1;
            for (int i = 0; i < DIGITS; i++) m_frame[(DIGITS - 1 - i) * 4 +: 4] = m_part[i];
            m_slot = 0;
         end else begin
            m_slot++;
         end
      end
      if (frame_valid) fv_seen++;
      if (bad_seg) bs_seen++;
      check("digit_valid", 32'(digit_valid), 32'(m_dv));
      check("bad_seg", 32'(bad_seg), 32'(m_bs));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("digit", 32'(digit), 32'(m_digit));
      check("digit_idx", 32'(digit_idx), 32'(m_idx));
      check("frame", frame, m_frame);
      check("bad_cnt", 32'(bad_cnt), 32'(m_bad));
      seg_valid = 0; clr = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dv"}, 32'(digit_valid), 32'd0);
      check({tag, "_digit"}, 32'(digit), 32'd0);
      check({tag, "_idx"}, 32'(digit_idx), 32'd0);
      check({tag, "_fv"}, 32'(frame_valid), 32'd0);
      check({tag, "_frame"}, frame, 32'd0);
      check({tag, "_bs"}, 32'(bad_seg), 32'd0);
      check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'd0);
   endtask

   initial begin
      int dg [8];
      int fv0, bs0;
      logic [6:0] p;
      model_reset();
      fv_seen = 0; bs_seen = 0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      dg = '{1, 9, 9, 8, 0, 1, 0, 3};
      fv0 = fv_seen;
      for (int i = 0; i < 8; i++) step(1, pat[dg[i]], 0);
      check("birth_frame", frame, 32'h19980103);
      check("birth_fv_count", 32'(fv_seen - fv0), 32'd1);

      fv0 = fv_seen;
      for (int i = 0; i < 10; i++) begin
         step(1, pat[i], 0);
         if (i == 7) check("seq_frame", frame, 32'h01234567);
         step(0, 7'd0, 0);
         step(0, 7'd0, 0);
      end
      check("seq_fv_count", 32'(fv_seen - fv0), 32'd1);
      check("seq_slot_after", 32'(digit_idx), 32'd1);

      step(0, 7'd0, 1);
      dg = '{1, 2, 3, 0, 4, 5, 6, 7};
      for (int i = 0; i < 8; i++) step(1, (i == 3) ? bad_pat : pat[dg[i]], 0);
      check("bad_frame", frame, 32'h123F4567);
      check("bad_frame_cnt", 32'(bad_cnt), 32'd1);

      for (int i = 0; i < 4; i++) step(1, pat[9 - i], 0);
      step(0, 7'd0, 1);
      for (int i = 0; i < 8; i++) step(1, pat[i + 2], 0);
      check("clr_frame", frame, 32'h23456789);
      step(1, pat[5], 1);
      check("clr_drop_dv", 32'(digit_valid), 32'd0);
      check("clr_drop_cnt", 32'(bad_cnt), 32'd0);

      bs0 = bs_seen;
      for (int i = 0; i < 17; i++) step(1, bad_pat, 0);
      check("sat_bad_cnt", 32'(bad_cnt), 32'd15);
      check("sat_bs_pulses", 32'(bs_seen - bs0), 32'd17);

      for (int i = 0; i < 5; i++) step(1, pat[i], 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      dg = '{2, 0, 2, 4, 1, 2, 3, 1};
      for (int i = 0; i < 8; i++) step(1, pat[dg[i]], 0);
      check("post_rst_frame", frame, 32'h20241231);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) < 80) p = pat[$urandom_range(0, 9)];
         else p = 7'($urandom);
         step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, p,
              ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
